// File: rtl/diff_commit_queue_if.sv
// Commit-queue bus: the multi-slot retire group coming in from the core and
// the single-entry difftest drain going out. The producer/consumer side uses
// the master modport and the queue uses the slave modport.
interface diff_commit_queue_if #(
    parameter int COMMIT_W = 2,
    parameter int XLEN     = 64,
    parameter int PC_W     = 64
);
    // retire group from the core
    logic [COMMIT_W-1:0]      in_valid;
    logic [COMMIT_W*PC_W-1:0] in_pc;
    logic [COMMIT_W*32-1:0]   in_instr;
    logic [COMMIT_W-1:0]      in_skip;
    logic [COMMIT_W-1:0]      in_wen;
    logic [COMMIT_W*8-1:0]    in_wdest;
    logic [COMMIT_W*XLEN-1:0] in_wdata;
    logic                     in_ready;

    // one commit per cycle towards the difftest consumer
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               out_index;
    logic [PC_W-1:0]          out_pc;
    logic [31:0]              out_instr;
    logic                     out_skip;
    logic                     out_wen;
    logic [7:0]               out_wdest;
    logic [XLEN-1:0]          out_wdata;

    modport master (
        output in_valid, in_pc, in_instr, in_skip, in_wen, in_wdest, in_wdata,
        input  in_ready,
        input  out_valid, out_index, out_pc, out_instr, out_skip, out_wen,
               out_wdest, out_wdata,
        output out_ready
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_skip, in_wen, in_wdest, in_wdata,
        output in_ready,
        output out_valid, out_index, out_pc, out_instr, out_skip, out_wen,
               out_wdest, out_wdata,
        input  out_ready
    );
endinterface

// File: rtl/diff_commit_queue.sv
// diff_commit_queue: compacts up to COMMIT_W retired instructions per cycle
// into a DEPTH-entry FIFO and drains one per cycle to the difftest consumer,
// stamping each drained entry with a wrapping 8-bit commit index.
// Optional feature macro: DIFF_TRAP_DETECT_EN -- adds halt/halt_pc outputs;
// draining an ebreak halts intake (no overflow while halted), drain continues.
module diff_commit_queue #(
    parameter int COMMIT_W = 2,
    parameter int DEPTH    = 16,
    parameter int XLEN     = 64,
    parameter int PC_W     = 64
) (
    input  logic                       clock,
    input  logic                       resetn,
    diff_commit_queue_if.slave         bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
`ifdef DIFF_TRAP_DETECT_EN
    ,
    output logic                       halt,
    output logic [PC_W-1:0]            halt_pc
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    // highest occupancy that still leaves room for a full group
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - COMMIT_W);
    localparam logic [31:0]   EBREAK    = 32'h0010_0073;

    // number of set bits in a slot mask
    function automatic logic [CW-1:0] popcount(input logic [COMMIT_W-1:0] v);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < COMMIT_W; i++) begin
            c = c + {{(CW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // payload storage (not reset; occupancy tracks validity)
    logic [PC_W-1:0] mem_pc_q    [DEPTH];
    logic [31:0]     mem_instr_q [DEPTH];
    logic            mem_skip_q  [DEPTH];
    logic            mem_wen_q   [DEPTH];
    logic [7:0]      mem_wdest_q [DEPTH];
    logic [XLEN-1:0] mem_wdata_q [DEPTH];

    logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [CW-1:0] count_q,     count_d;
    logic [7:0]    out_index_q, out_index_d;
    logic          overflow_q,  overflow_d;

    logic          halted_s;
    logic          room_s;
    logic          in_ready_s;
    logic          any_valid_s;
    logic          push_s;
    logic          pop_s;
    logic          out_valid_s;
    logic [CW-1:0] push_n_s;
    logic [COMMIT_W-1:0] wr_en_s;
    logic [PW-1:0]       wr_addr_s [COMMIT_W];

`ifdef DIFF_TRAP_DETECT_EN
    logic            halt_q,    halt_d;
    logic [PC_W-1:0] halt_pc_q, halt_pc_d;
    assign halted_s = halt_q;
`else
    assign halted_s = 1'b0;
`endif

    // head view: combinational read of the entry under the registered rd_ptr
    always_comb begin
        out_valid_s   = (count_q != {CW{1'b0}});
        bus.out_valid = out_valid_s;
        bus.out_index = out_index_q;
        bus.out_pc    = mem_pc_q[rd_ptr_q];
        bus.out_instr = mem_instr_q[rd_ptr_q];
        bus.out_skip  = mem_skip_q[rd_ptr_q];
        bus.out_wen   = mem_wen_q[rd_ptr_q] && (mem_wdest_q[rd_ptr_q] != 8'h00);
        bus.out_wdest = mem_wdest_q[rd_ptr_q];
        bus.out_wdata = mem_wdata_q[rd_ptr_q];
    end

    // push/pop decisions, slot compaction and next-state for all counters
    always_comb begin
        logic [PW-1:0] slot_off_v;

        room_s      = (count_q <= READY_MAX);
        in_ready_s  = room_s && !halted_s;
        any_valid_s = |bus.in_valid;
        push_s      = in_ready_s && any_valid_s;
        pop_s       = out_valid_s && bus.out_ready;
        push_n_s    = push_s ? popcount(bus.in_valid) : {CW{1'b0}};

        // valid slots land at consecutive addresses in ascending slot order
        slot_off_v = {PW{1'b0}};
        for (int i = 0; i < COMMIT_W; i++) begin
            wr_en_s[i]   = push_s && bus.in_valid[i];
            wr_addr_s[i] = wr_ptr_q + slot_off_v;
            if (bus.in_valid[i]) begin
                slot_off_v = slot_off_v + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                slot_off_v = slot_off_v;
            end
        end

        wr_ptr_d    = wr_ptr_q + push_n_s[PW-1:0];
        rd_ptr_d    = pop_s ? (rd_ptr_q + {{(PW-1){1'b0}}, 1'b1}) : rd_ptr_q;
        out_index_d = pop_s ? (out_index_q + 8'd1) : out_index_q;
        count_d     = count_q + push_n_s - {{(CW-1){1'b0}}, pop_s};
        // a group offered while there is no room is lost; a halted queue
        // refuses intake on purpose and does not count that as loss
        overflow_d  = overflow_q || (any_valid_s && !room_s && !halted_s);
    end

    assign bus.in_ready = in_ready_s;
    assign count        = count_q;
    assign overflow     = overflow_q;

`ifdef DIFF_TRAP_DETECT_EN
    // latch the first ebreak seen leaving the queue
    always_comb begin
        halt_d    = halt_q;
        halt_pc_d = halt_pc_q;
        if (pop_s && !halt_q && (mem_instr_q[rd_ptr_q] == EBREAK)) begin
            halt_d    = 1'b1;
            halt_pc_d = mem_pc_q[rd_ptr_q];
        end else begin
            halt_d    = halt_q;
            halt_pc_d = halt_pc_q;
        end
    end

    // halt state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            halt_q    <= 1'b0;
            halt_pc_q <= {PC_W{1'b0}};
        end else begin
            halt_q    <= halt_d;
            halt_pc_q <= halt_pc_d;
        end
    end

    assign halt    = halt_q;
    assign halt_pc = halt_pc_q;
`else
    // without trap detection the ebreak encoding is never decoded
    logic unused_ebreak_s;
    assign unused_ebreak_s = ^EBREAK;
`endif

    // control state: pointers, occupancy, commit index, sticky overflow
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q    <= {PW{1'b0}};
            wr_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            out_index_q <= 8'd0;
            overflow_q  <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_index_q <= out_index_d;
            overflow_q  <= overflow_d;
        end
    end

    // payload write for each accepted slot
    always_ff @(posedge clock) begin
        for (int i = 0; i < COMMIT_W; i++) begin
            if (wr_en_s[i]) begin
                mem_pc_q[wr_addr_s[i]]    <= bus.in_pc[i*PC_W +: PC_W];
                mem_instr_q[wr_addr_s[i]] <= bus.in_instr[i*32 +: 32];
                mem_skip_q[wr_addr_s[i]]  <= bus.in_skip[i];
                mem_wen_q[wr_addr_s[i]]   <= bus.in_wen[i];
                mem_wdest_q[wr_addr_s[i]] <= bus.in_wdest[i*8 +: 8];
                mem_wdata_q[wr_addr_s[i]] <= bus.in_wdata[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: tb/tb_diff_commit_queue.sv
// Directed bench for diff_commit_queue (COMMIT_W=2, DEPTH=16): a vector table
// for basic push/pop/compaction, then hand sequences for fill/overflow,
// index wrap streaming, reset discard, full-boundary push+pop and (when
// DIFF_TRAP_DETECT_EN is defined) ebreak halt.
module tb_diff_commit_queue;

    localparam int CW_T = 2;
    localparam int DP_T = 16;

    logic        clock;
    logic        resetn;
    logic [4:0]  count;
    logic        overflow;
`ifdef DIFF_TRAP_DETECT_EN
    logic        halt;
    logic [63:0] halt_pc;
`endif

    int checks;
    int failures;

    diff_commit_queue_if #(.COMMIT_W(CW_T), .XLEN(64), .PC_W(64)) bus ();

    diff_commit_queue #(.COMMIT_W(CW_T), .DEPTH(DP_T), .XLEN(64), .PC_W(64)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .bus      (bus),
        .count    (count),
        .overflow (overflow)
`ifdef DIFF_TRAP_DETECT_EN
        ,
        .halt     (halt),
        .halt_pc  (halt_pc)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return {pc[31:2], 2'b11};
    endfunction
    function automatic logic [7:0] wdest_of(input logic [63:0] pc);
        return pc[9:2];
    endfunction
    function automatic logic [63:0] wdata_of(input logic [63:0] pc);
        return ~pc ^ 64'h5a5a;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // full payload check of the head entry
    task automatic chk_head(input string name, input logic [63:0] pc);
        chk({name, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
        chk({name, "_pc"},    bus.out_pc, pc);
        chk({name, "_instr"}, {32'd0, bus.out_instr}, {32'd0, instr_of(pc)});
        chk({name, "_skip"},  {63'd0, bus.out_skip}, {63'd0, pc[2]});
        chk({name, "_wdest"}, {56'd0, bus.out_wdest}, {56'd0, wdest_of(pc)});
        chk({name, "_wen"},   {63'd0, bus.out_wen}, {63'd0, (wdest_of(pc) != 8'd0)});
        chk({name, "_wdata"}, bus.out_wdata, wdata_of(pc));
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] pc0,
                         input logic [63:0] pc1, input logic ordy);
        bus.in_valid  = v;
        bus.in_pc     = {pc1, pc0};
        bus.in_instr  = {instr_of(pc1), instr_of(pc0)};
        bus.in_skip   = {pc1[2], pc0[2]};
        bus.in_wen    = 2'b11;
        bus.in_wdest  = {wdest_of(pc1), wdest_of(pc0)};
        bus.in_wdata  = {wdata_of(pc1), wdata_of(pc0)};
        bus.out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [63:0] pc0;
        logic [63:0] pc1;
        logic        ordy;
        logic [4:0]  e_count;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [7:0]  e_idx;
        logic        e_rdy;
    } vec_t;

    vec_t vecs [11];
    logic [63:0] pcq [$];
    logic [7:0]  idx_m;
    int          pushed;
    int          popped;

    initial begin
        checks   = 0;
        failures = 0;

        // inputs, then expected state after the clock edge
        vecs[0]  = '{2'b11, 64'h8000_0000, 64'h8000_0004, 1'b1, 5'd2, 1'b1, 64'h8000_0000, 8'd0, 1'b1};
        vecs[1]  = '{2'b00, 64'h0,         64'h0,         1'b1, 5'd1, 1'b1, 64'h8000_0004, 8'd1, 1'b1};
        vecs[2]  = '{2'b00, 64'h0,         64'h0,         1'b1, 5'd0, 1'b0, 64'h0,         8'd2, 1'b1};
        vecs[3]  = '{2'b10, 64'h200,       64'h100,       1'b1, 5'd1, 1'b1, 64'h100,       8'd2, 1'b1};
        vecs[4]  = '{2'b00, 64'h0,         64'h0,         1'b0, 5'd1, 1'b1, 64'h100,       8'd2, 1'b1};
        vecs[5]  = '{2'b01, 64'h300,       64'h304,       1'b1, 5'd1, 1'b1, 64'h300,       8'd3, 1'b1};
        vecs[6]  = '{2'b11, 64'h400,       64'h404,       1'b0, 5'd3, 1'b1, 64'h300,       8'd3, 1'b1};
        vecs[7]  = '{2'b10, 64'h500,       64'h408,       1'b1, 5'd3, 1'b1, 64'h400,       8'd4, 1'b1};
        vecs[8]  = '{2'b00, 64'h0,         64'h0,         1'b1, 5'd2, 1'b1, 64'h404,       8'd5, 1'b1};
        vecs[9]  = '{2'b00, 64'h0,         64'h0,         1'b1, 5'd1, 1'b1, 64'h408,       8'd6, 1'b1};
        vecs[10] = '{2'b00, 64'h0,         64'h0,         1'b1, 5'd0, 1'b0, 64'h0,         8'd7, 1'b1};

        // reset state
        resetn = 1'b0;
        drive(2'b00, 64'h0, 64'h0, 1'b0);
        repeat (2) @(negedge clock);
        chk("rst_count",    {59'd0, count}, 64'd0);
        chk("rst_valid",    {63'd0, bus.out_valid}, 64'd0);
        chk("rst_index",    {56'd0, bus.out_index}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        resetn = 1'b1;
        @(negedge clock);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // table: group push, compaction of masks, stall, simultaneous push+pop
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].valid, vecs[i].pc0, vecs[i].pc1, vecs[i].ordy);
            step();
            chk($sformatf("v%0d_count", i), {59'd0, count}, {59'd0, vecs[i].e_count});
            chk($sformatf("v%0d_valid", i), {63'd0, bus.out_valid}, {63'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_index", i), {56'd0, bus.out_index}, {56'd0, vecs[i].e_idx});
            chk($sformatf("v%0d_in_ready", i), {63'd0, bus.in_ready}, {63'd0, vecs[i].e_rdy});
            if (vecs[i].e_valid) begin
                chk_head($sformatf("v%0d_head", i), vecs[i].e_pc);
            end
        end

        // fill to DEPTH with the consumer stalled, then offer one more group
        for (int k = 0; k < 8; k++) begin
            drive(2'b11, 64'h1000 + 64'(8*k), 64'h1004 + 64'(8*k), 1'b0);
            step();
            chk($sformatf("fill%0d_count", k), {59'd0, count}, 64'(2*(k+1)));
            chk($sformatf("fill%0d_in_ready", k), {63'd0, bus.in_ready}, {63'd0, (2*(k+1) <= 14)});
        end
        drive(2'b11, 64'h1100, 64'h1104, 1'b0);
        step();
        chk("full_overflow", {63'd0, overflow}, 64'd1);
        chk("full_count",    {59'd0, count}, 64'd16);
        chk_head("full_head", 64'h1000);
        chk("full_index",    {56'd0, bus.out_index}, 64'd7);
        drive(2'b00, 64'h0, 64'h0, 1'b1);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("drain%0d_pc", j), bus.out_pc, 64'h1000 + 64'(4*j));
            chk($sformatf("drain%0d_index", j), {56'd0, bus.out_index}, 64'(7 + j));
            step();
        end
        chk("drain_count",    {59'd0, count}, 64'd0);
        chk("drain_overflow", {63'd0, overflow}, 64'd1);

        // stream 300 commits through, index wraps past 255
        idx_m  = 8'd23;
        pushed = 0;
        popped = 0;
        for (int cyc = 0; cyc < 400 && popped < 300; cyc++) begin
            chk("stream_count", {59'd0, count}, 64'(pcq.size()));
            if (bus.out_valid) begin
                if (pcq.size() == 0) begin
                    chk("stream_extra", 64'd1, 64'd0);
                end else begin
                    chk("stream_pc", bus.out_pc, pcq[0]);
                    chk("stream_index", {56'd0, bus.out_index}, {56'd0, idx_m});
                    void'(pcq.pop_front());
                end
                idx_m  = idx_m + 8'd1;
                popped = popped + 1;
            end
            if (pushed < 300 && (cyc % 2) == 0) begin
                drive(2'b11, 64'h8000_0000 + 64'(4*pushed), 64'h8000_0004 + 64'(4*pushed), 1'b1);
                pcq.push_back(64'h8000_0000 + 64'(4*pushed));
                pcq.push_back(64'h8000_0004 + 64'(4*pushed));
                pushed = pushed + 2;
            end else begin
                drive(2'b00, 64'h0, 64'h0, 1'b1);
            end
            step();
        end
        chk("stream_popped", 64'(popped), 64'd300);
        chk("stream_wrap_index", {56'd0, bus.out_index}, 64'd67);

        // asynchronous reset with 9 entries buffered discards them at once
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 64'h1800 + 64'(8*k), 64'h1804 + 64'(8*k), 1'b0);
            step();
        end
        drive(2'b01, 64'h1840, 64'h1844, 1'b0);
        step();
        chk("pre_rst_count", {59'd0, count}, 64'd9);
        drive(2'b00, 64'h0, 64'h0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_count",    {59'd0, count}, 64'd0);
        chk("mid_rst_valid",    {63'd0, bus.out_valid}, 64'd0);
        chk("mid_rst_index",    {56'd0, bus.out_index}, 64'd0);
        chk("mid_rst_overflow", {63'd0, overflow}, 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        step();
        chk("post_rst_count", {59'd0, count}, 64'd0);

        // push+pop at the full boundary
        for (int k = 0; k < 7; k++) begin
            drive(2'b11, 64'h2000 + 64'(8*k), 64'h2004 + 64'(8*k), 1'b0);
            step();
        end
        chk("b14_count",    {59'd0, count}, 64'd14);
        chk("b14_in_ready", {63'd0, bus.in_ready}, 64'd1);
        drive(2'b11, 64'h3000, 64'h3004, 1'b1);
        step();
        chk("b15_count",    {59'd0, count}, 64'd15);
        chk("b15_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("b15_overflow", {63'd0, overflow}, 64'd0);
        chk("b15_index",    {56'd0, bus.out_index}, 64'd1);
        chk_head("b15_head", 64'h2004);
        drive(2'b11, 64'h3008, 64'h300c, 1'b1);
        step();
        chk("b15p_count",    {59'd0, count}, 64'd14);
        chk("b15p_overflow", {63'd0, overflow}, 64'd1);
        chk("b15p_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("b15p_index",    {56'd0, bus.out_index}, 64'd2);
        drive(2'b00, 64'h0, 64'h0, 1'b1);
        for (int j = 0; j < 12; j++) begin
            chk($sformatf("bdrain%0d_pc", j), bus.out_pc, 64'h2008 + 64'(4*j));
            step();
        end
        chk_head("bdrain_last0", 64'h3000);
        step();
        chk_head("bdrain_last1", 64'h3004);
        step();
        chk("bdrain_count", {59'd0, count}, 64'd0);
        chk("bdrain_valid", {63'd0, bus.out_valid}, 64'd0);

`ifdef DIFF_TRAP_DETECT_EN
        // ebreak drained from the queue halts intake but not drain
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        chk("trap_rst_halt", {63'd0, halt}, 64'd0);
        drive(2'b11, 64'h8000_000c, 64'h8000_0010, 1'b0);
        bus.in_instr[63:32] = 32'h0010_0073;
        step();
        drive(2'b11, 64'h8000_0014, 64'h8000_0018, 1'b0);
        step();
        chk("trap_count4", {59'd0, count}, 64'd4);
        drive(2'b00, 64'h0, 64'h0, 1'b1);
        step();
        chk("trap_pre_halt", {63'd0, halt}, 64'd0);
        step();
        chk("trap_halt",     {63'd0, halt}, 64'd1);
        chk("trap_halt_pc",  halt_pc, 64'h8000_0010);
        chk("trap_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("trap_count2",   {59'd0, count}, 64'd2);
        drive(2'b11, 64'h9000, 64'h9004, 1'b1);
        step();
        chk("trap_ign_count",    {59'd0, count}, 64'd1);
        chk("trap_ign_overflow", {63'd0, overflow}, 64'd0);
        drive(2'b00, 64'h0, 64'h0, 1'b1);
        step();
        chk("trap_empty",          {59'd0, count}, 64'd0);
        chk("trap_empty_in_ready", {63'd0, bus.in_ready}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
